// File: rtl/mem_access_seq_pkg.sv
// mem_access_seq_pkg
//   Shared types for the MEM-stage data-memory sequencer.
//   - lc3b_word      : 16-bit machine word
//   - lc3b_mem_state : sequencer states (IDLE, IND, HOLD)
//   - byte-enable constants and the store byte-enable helper
package mem_access_seq_pkg;

  localparam int LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    HOLD = 2'd2
  } lc3b_mem_state;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Odd byte address writes the high lane, even writes the low lane.
  function automatic logic [1:0] stb_byte_en(input logic addr_lsb);
    return addr_lsb ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if
//   Data-memory request/response bus.
//   master : sequencer side (drives read/write/address/wdata/byte_en)
//   slave  : memory side (drives resp/rdata)
//   read/write : request strobes, held until resp
//   address    : word-aligned by the memory
//   byte_en    : write lane enables
//   resp       : one-cycle completion pulse, rdata valid alongside it
interface mem_access_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        byte_en;
  logic              resp;
  logic [DATA_W-1:0] rdata;

  modport master (
    output read, write, address, wdata, byte_en,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata, byte_en,
    output resp, rdata
  );
endinterface

// File: rtl/mem_access_seq_byte_lane_fmt.sv
// mem_access_seq_byte_lane_fmt
//   Combinational byte-lane formatting for LDB/STB.
//   i_byte_op    : byte access (LDB/STB)
//   i_addr_lsb   : byte select within the word
//   i_store_data : store data from the pipeline
//   i_load_data  : raw word returned by memory
//   o_store_data : byte replicated on both lanes for byte stores, else word
//   o_byte_en    : lane enables (one lane for byte stores, both otherwise)
//   o_load_data  : zero-extended selected byte for byte loads, else word
module mem_access_seq_byte_lane_fmt
  import mem_access_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_byte_op,
  input  logic              i_addr_lsb,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_load_data,
  output logic [DATA_W-1:0] o_store_data,
  output logic [1:0]        o_byte_en,
  output logic [DATA_W-1:0] o_load_data
);

  logic [7:0] w_load_byte;

  assign w_load_byte  = i_addr_lsb ? i_load_data[15:8] : i_load_data[7:0];

  assign o_store_data = i_byte_op ? {(DATA_W/8){i_store_data[7:0]}} : i_store_data;
  assign o_byte_en    = i_byte_op ? stb_byte_en(i_addr_lsb) : BE_WORD;
  assign o_load_data  = i_byte_op ? {{(DATA_W-8){1'b0}}, w_load_byte} : i_load_data;

endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq
//   MEM-stage data-memory sequencer. Issues the access described by the
//   control word, runs the two-access LDI/STI sequence (pointer fetch, then
//   the real access), formats LDB/STB lanes and stalls the pipeline until
//   the last access of the instruction completes.
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     valid             : MEM slot holds a real instruction
//     mem_read/write    : first-access direction
//     mem_readi/writei  : second (indirect) access direction
//     byte_op           : LDB/STB byte access
//     addr, wdata       : effective address, store data
//     advance           : pipeline registers load this cycle
//     dmem              : memory bus (master modport)
//     mem_rdata         : formatted load result
//     mem_stall         : hold the pipeline (combinational)
//   Optional build macro MEM_PERF_CNT_EN adds saturating stall_cnt and
//   access_cnt outputs.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_readi,
  input  logic              mem_writei,
  input  logic              byte_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              advance,
  mem_access_seq_if.master  dmem,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  access_cnt
`endif
);

  lc3b_mem_state     r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rdata;

  logic              w_indirect;
  logic              w_start;
  logic              w_final_resp;
  logic              w_fmt_byte;
  logic [DATA_W-1:0] w_load_src;
  logic [DATA_W-1:0] w_store_fmt;
  logic [1:0]        w_byte_en;

  assign w_indirect   = mem_readi | mem_writei;
  // reset_n gating makes requests and stall drop the moment reset asserts,
  // even though IDLE requests are otherwise driven straight from the inputs.
  assign w_start      = reset_n & (r_state == IDLE) & valid & (mem_read | mem_write);
  assign w_final_resp = dmem.resp & ((w_start & ~w_indirect) | (r_state == IND));
  assign mem_stall    = (w_start | (r_state == IND)) & ~w_final_resp;

  // The indirect access is always a full word.
  assign w_fmt_byte   = byte_op & (r_state != IND);
  assign w_load_src   = w_final_resp ? dmem.rdata : r_rdata;

  mem_access_seq_byte_lane_fmt #(
    .DATA_W (DATA_W)
  ) u_fmt (
    .i_byte_op    (w_fmt_byte),
    .i_addr_lsb   (addr[0]),
    .i_store_data (wdata),
    .i_load_data  (w_load_src),
    .o_store_data (w_store_fmt),
    .o_byte_en    (w_byte_en),
    .o_load_data  (mem_rdata)
  );

  always_comb begin
    dmem.read    = 1'b0;
    dmem.write   = 1'b0;
    dmem.address = addr;
    dmem.wdata   = w_store_fmt;
    dmem.byte_en = w_byte_en;
    case (r_state)
      IDLE: begin
        dmem.read  = reset_n & valid & mem_read;
        dmem.write = reset_n & valid & mem_write;
      end
      IND: begin
        dmem.address = r_ptr;
        dmem.read    = mem_readi;
        dmem.write   = mem_writei;
      end
      default: begin
        // HOLD: result already captured; issue nothing while stalled elsewhere.
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start && dmem.resp) begin
            if (w_indirect) begin
              r_ptr   <= dmem.rdata[ADDR_W-1:0];
              r_state <= IND;
            end else begin
              r_rdata <= dmem.rdata;
              r_state <= advance ? IDLE : HOLD;
            end
          end
        end
        IND: begin
          if (dmem.resp) begin
            r_rdata <= dmem.rdata;
            r_state <= advance ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (advance) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_access_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= '0;
      r_access_cnt <= '0;
    end else begin
      if (mem_stall && !(&r_stall_cnt))  r_stall_cnt  <= r_stall_cnt + 1'b1;
      if (dmem.resp && !(&r_access_cnt)) r_access_cnt <= r_access_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign access_cnt = r_access_cnt;
`endif

`ifndef SYNTHESIS
  // Stall status of the previous cycle: a stalled slot must keep valid high.
  logic r_stall_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stall_prev <= 1'b0;
    else          r_stall_prev <= mem_stall;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      a_no_rw_both: assert (!(dmem.read && dmem.write));
      if (r_stall_prev) begin
        a_valid_held: assert (valid);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid, mem_read, mem_write, mem_readi, mem_writei, byte_op, advance;
  logic [15:0] addr, wdata;
  logic [15:0] mem_rdata;
  logic        mem_stall;

  int errors = 0;
  int checks = 0;

  mem_access_seq_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_access_seq #(.ADDR_W(16), .DATA_W(16), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_readi  (mem_readi),
    .mem_writei (mem_writei),
    .byte_op    (byte_op),
    .addr       (addr),
    .wdata      (wdata),
    .advance    (advance),
    .dmem       (bus),
    .mem_rdata  (mem_rdata),
    .mem_stall  (mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic v, input logic rd, input logic wr, input logic rdi,
                         input logic wri, input logic bop, input logic [15:0] a,
                         input logic [15:0] wd);
    valid = v; mem_read = rd; mem_write = wr; mem_readi = rdi;
    mem_writei = wri; byte_op = bop; addr = a; wdata = wd;
  endtask

  task automatic set_mem(input logic rsp, input logic [15:0] rd, input logic adv);
    bus.resp = rsp; bus.rdata = rd; advance = adv;
  endtask

  initial begin
    reset_n = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    set_mem(0, 16'h0000, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read",  bus.read,  0);
    chk("rst_write", bus.write, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_rdata", mem_rdata, 16'h0000);
    @(negedge clk); reset_n = 1'b1;

    // LDR 0x1000: three wait cycles, then resp 0xBEEF
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_ctl(1, 1, 0, 0, 0, 0, 16'h1000, 16'h0000); set_mem(0, 16'h0000, 0);
      #1;
      chk("ldr_wait_stall", mem_stall,    1);
      chk("ldr_wait_read",  bus.read,     1);
      chk("ldr_wait_write", bus.write,    0);
      chk("ldr_wait_addr",  bus.address,  16'h1000);
    end
    @(negedge clk); set_mem(1, 16'hBEEF, 1); #1;
    chk("ldr_done_stall", mem_stall, 0);
    chk("ldr_done_rdata", mem_rdata, 16'hBEEF);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); set_mem(0, 16'h0000, 1); #1;
    chk("ldr_after_read",  bus.read,  0);
    chk("ldr_after_stall", mem_stall, 0);

    // LDI 0x2000 -> pointer 0x3000 -> data 0x1234
    @(negedge clk); set_ctl(1, 1, 0, 1, 0, 0, 16'h2000, 16'h0000); set_mem(0, 16'h0000, 0); #1;
    chk("ldi_p1_stall", mem_stall,   1);
    chk("ldi_p1_addr",  bus.address, 16'h2000);
    @(negedge clk); set_mem(1, 16'h3000, 0); #1;
    chk("ldi_p1_resp_stall", mem_stall, 1);
    @(negedge clk); set_mem(0, 16'h0000, 0); #1;
    chk("ldi_p2_addr",  bus.address, 16'h3000);
    chk("ldi_p2_read",  bus.read,    1);
    chk("ldi_p2_stall", mem_stall,   1);
    @(negedge clk); set_mem(1, 16'h1234, 1); #1;
    chk("ldi_done_stall", mem_stall,   0);
    chk("ldi_done_rdata", mem_rdata,   16'h1234);
    chk("ldi_done_addr",  bus.address, 16'h3000);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); set_mem(0, 16'h0000, 1); #1;
    chk("ldi_after_read", bus.read, 0);

    // STB 0x4001 wdata 0x00AB
    @(negedge clk); set_ctl(1, 0, 1, 0, 0, 1, 16'h4001, 16'h00AB); set_mem(0, 16'h0000, 0); #1;
    chk("stb_wdata", bus.wdata,   16'hABAB);
    chk("stb_be",    bus.byte_en, 2'b10);
    chk("stb_write", bus.write,   1);
    chk("stb_read",  bus.read,    0);
    chk("stb_stall", mem_stall,   1);
    @(negedge clk); set_mem(1, 16'h0000, 1); #1;
    chk("stb_done_stall", mem_stall, 0);

    // STW 0x4000 wdata 0x5678, zero-wait response
    @(negedge clk); set_ctl(1, 0, 1, 0, 0, 0, 16'h4000, 16'h5678); set_mem(1, 16'h0000, 1); #1;
    chk("stw_wdata", bus.wdata,   16'h5678);
    chk("stw_be",    bus.byte_en, 2'b11);
    chk("stw_stall", mem_stall,   0);

    // STB even address uses low lane
    @(negedge clk); set_ctl(1, 0, 1, 0, 0, 1, 16'h4002, 16'h1234); set_mem(1, 16'h0000, 1); #1;
    chk("stb_even_wdata", bus.wdata,   16'h3434);
    chk("stb_even_be",    bus.byte_en, 2'b01);

    // LDB high and low byte, zero-wait
    @(negedge clk); set_ctl(1, 1, 0, 0, 0, 1, 16'h5001, 16'h0000); set_mem(1, 16'hCD12, 1); #1;
    chk("ldb_hi_rdata", mem_rdata, 16'h00CD);
    chk("ldb_hi_stall", mem_stall, 0);
    @(negedge clk); set_ctl(1, 1, 0, 0, 0, 1, 16'h5000, 16'h0000); set_mem(1, 16'hCD92, 1); #1;
    chk("ldb_lo_rdata", mem_rdata, 16'h0092);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); set_mem(0, 16'h0000, 1); #1;
    chk("ldb_after_write", bus.write, 0);

    // Final response with advance low -> HOLD for two cycles
    @(negedge clk); set_ctl(1, 1, 0, 0, 0, 0, 16'h6000, 16'h0000); set_mem(1, 16'h7777, 0); #1;
    chk("hold_resp_stall", mem_stall, 0);
    chk("hold_resp_rdata", mem_rdata, 16'h7777);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); set_mem(0, 16'h0F0F, 0); #1;
      chk("hold_read",  bus.read,  0);
      chk("hold_stall", mem_stall, 0);
      chk("hold_rdata", mem_rdata, 16'h7777);
    end
    @(negedge clk); set_mem(0, 16'h0F0F, 1); #1;
    chk("hold_adv_read", bus.read, 0);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); set_mem(0, 16'h0000, 1); #1;
    chk("hold_exit_read", bus.read, 0);

    // Reset while in IND
    @(negedge clk); set_ctl(1, 1, 0, 1, 0, 0, 16'h2000, 16'h0000); set_mem(1, 16'h3000, 0); #1;
    chk("rind_p1_stall", mem_stall, 1);
    @(negedge clk); set_mem(0, 16'h0000, 0); #1;
    chk("rind_addr", bus.address, 16'h3000);
    chk("rind_read", bus.read,    1);
    #2; reset_n = 1'b0; #1;
    chk("rind_rst_read",  bus.read,  0);
    chk("rind_rst_write", bus.write, 0);
    chk("rind_rst_stall", mem_stall, 0);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); reset_n = 1'b1;
    @(negedge clk); set_ctl(1, 1, 0, 0, 0, 0, 16'h1000, 16'h0000); set_mem(0, 16'h0000, 0); #1;
    chk("post_rst_addr",  bus.address, 16'h1000);
    chk("post_rst_stall", mem_stall,   1);
    @(negedge clk); set_mem(1, 16'hA5A5, 1); #1;
    chk("post_rst_rdata", mem_rdata, 16'hA5A5);
    chk("post_rst_done",  mem_stall, 0);
    @(negedge clk); set_ctl(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); set_mem(0, 16'h0000, 1); #1;
    chk("post_rst_held", mem_rdata, 16'hA5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
